// File: rtl/enoc_pkg.sv
// Shared ENoC definitions: port indices, port vector types and the mod-5 helpers
// used by the switch allocator and its per-output arbiters.
package enoc_pkg;

    localparam int NUM_PORTS = 5;

    typedef logic [0:4] port_onehot_t;
    typedef logic [2:0] port_idx_t;

    localparam port_idx_t PORT_C = 3'd0;
    localparam port_idx_t PORT_N = 3'd1;
    localparam port_idx_t PORT_E = 3'd2;
    localparam port_idx_t PORT_S = 3'd3;
    localparam port_idx_t PORT_W = 3'd4;

    function automatic port_idx_t inc_mod5(input port_idx_t p);
        return (p >= PORT_W) ? PORT_C : p + 3'd1;
    endfunction

    function automatic port_onehot_t idx_to_onehot(input port_idx_t p);
        port_onehot_t v;
        v = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (port_idx_t'(k) == p) begin
                v[k] = 1'b1;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/enoc_rr_arbiter.sv
// Five-requester round-robin arbiter for a single output port, with optional
// wormhole locking that holds the output for one input from head to tail flit.
module enoc_rr_arbiter
    import enoc_pkg::*;
#(
    parameter bit WORMHOLE = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  port_onehot_t req,
    input  port_onehot_t tail,
    input  logic         en,
    output port_onehot_t grant,
    output logic         val
);

    port_idx_t    ptr;
    logic         lock;
    port_idx_t    owner;

    port_onehot_t cand;
    port_idx_t    winner;
    port_idx_t    idx;
    logic         found;
    port_onehot_t winner_oh;
    logic         winner_tail;
    logic         transfer;

    // A locked output only listens to its owner; otherwise search from ptr upward.
    always_comb begin
        cand   = lock ? (req & idx_to_onehot(owner)) : req;
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < NUM_PORTS; k++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (!found && (port_idx_t'(j) == idx) && cand[j]) begin
                    found  = 1'b1;
                    winner = port_idx_t'(j);
                end
            end
            idx = inc_mod5(idx);
        end
    end

    always_comb begin
        winner_oh   = idx_to_onehot(winner);
        winner_tail = |(tail & winner_oh);
        transfer    = found && en && !reset;
        grant       = transfer ? winner_oh : '0;
        val         = transfer;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= PORT_C;
            lock  <= 1'b0;
            owner <= PORT_C;
        end else if (transfer) begin
            if (WORMHOLE) begin
                if (winner_tail) begin
                    lock <= 1'b0;
                    ptr  <= inc_mod5(winner);
                end else begin
                    lock  <= 1'b1;
                    owner <= winner;
                end
            end else begin
                ptr <= inc_mod5(winner);
            end
        end
    end

endmodule

// File: rtl/enoc_switch_allocator.sv
// ENoC router switch allocator: one round-robin arbiter per output port, fed by
// the transposed route requests; grants drive the crossbar and input FIFO pops.
module enoc_switch_allocator
    import enoc_pkg::*;
#(
    parameter bit WORMHOLE = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:4][0:4] i_output_req,
    input  logic [0:4]      i_tail,
    input  logic [0:4]      i_en,
    output logic [0:4]      o_input_grant,
    output logic [0:4][0:4] o_output_sel,
    output logic [0:4]      o_output_val
);

    port_onehot_t out_req   [NUM_PORTS];
    port_onehot_t out_grant [NUM_PORTS];

    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            out_req[o] = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                out_req[o][i] = i_output_req[i][o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        enoc_rr_arbiter #(
            .WORMHOLE (WORMHOLE)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (out_req[o]),
            .tail  (i_tail),
            .en    (i_en[o]),
            .grant (out_grant[o]),
            .val   (o_output_val[o])
        );
        assign o_output_sel[o] = out_grant[o];
    end

    // Each input asks for at most one output, so a plain OR never merges two grants.
    always_comb begin
        o_input_grant = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            o_input_grant = o_input_grant | out_grant[o];
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_req_chk
        a_req_onehot : assert property (@(posedge clk) disable iff (reset)
            $onehot0(i_output_req[i]));
    end

endmodule

// File: tb/tb_enoc_switch_allocator.sv
// Directed bench for enoc_switch_allocator: a wormhole and a flit-interleaved
// instance share stimulus; expected selects and grants are worked out by hand.
module tb_enoc_switch_allocator;

    localparam int NONE = -1;
    localparam int C = 0;
    localparam int N = 1;
    localparam int E = 2;
    localparam int S = 3;
    localparam int W = 4;

    logic            clk;
    logic            reset;
    logic [0:4][0:4] req;
    logic [0:4]      tail;
    logic [0:4]      en;

    logic [0:4]      wh_grant;
    logic [0:4][0:4] wh_sel;
    logic [0:4]      wh_val;
    logic [0:4]      nw_grant;
    logic [0:4][0:4] nw_sel;
    logic [0:4]      nw_val;

    int checks = 0;
    int errors = 0;
    int cnt [5];

    enoc_switch_allocator #(.WORMHOLE(1'b1)) dut_wh (
        .clk           (clk),
        .reset         (reset),
        .i_output_req  (req),
        .i_tail        (tail),
        .i_en          (en),
        .o_input_grant (wh_grant),
        .o_output_sel  (wh_sel),
        .o_output_val  (wh_val)
    );

    enoc_switch_allocator #(.WORMHOLE(1'b0)) dut_nw (
        .clk           (clk),
        .reset         (reset),
        .i_output_req  (req),
        .i_tail        (tail),
        .i_en          (en),
        .o_input_grant (nw_grant),
        .o_output_sel  (nw_sel),
        .o_output_val  (nw_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [0:4][0:4] mk_req(input int d0, input int d1, input int d2,
                                                input int d3, input int d4);
        logic [0:4][0:4] r;
        int d [5];
        d = '{d0, d1, d2, d3, d4};
        r = '0;
        for (int i = 0; i < 5; i++) begin
            if (d[i] >= 0) r[i][d[i]] = 1'b1;
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic rst, input logic [0:4][0:4] r,
                                 input logic [4:0] t, input logic [4:0] e);
        @(negedge clk);
        reset = rst;
        req   = r;
        tail  = t;
        en    = e;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [4:0] actual,
                               input logic [4:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b", tag, actual, expected);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        tail  = '0;
        en    = '1;

        // Reset holds every output low even with live requests.
        applyStimulus(1'b1, mk_req(E, E, NONE, NONE, NONE), 5'b11000, 5'b11111);
        checkOutput("rst_val",   wh_val,   5'b00000);
        checkOutput("rst_grant", wh_grant, 5'b00000);
        checkOutput("rst_nw",    nw_grant, 5'b00000);
        applyStimulus(1'b1, mk_req(E, E, NONE, NONE, NONE), 5'b11000, 5'b11111);
        checkOutput("rst_sel_e", wh_sel[E], 5'b00000);

        applyStimulus(1'b0, mk_req(E, E, NONE, NONE, NONE), 5'b11000, 5'b11111);
        checkOutput("rel_sel_e0",  wh_sel[E], 5'b10000);
        checkOutput("rel_grant0",  wh_grant,  5'b10000);
        checkOutput("rel_nw_sel0", nw_sel[E], 5'b10000);
        applyStimulus(1'b0, mk_req(E, E, NONE, NONE, NONE), 5'b11000, 5'b11111);
        checkOutput("rel_sel_e1",  wh_sel[E], 5'b01000);
        checkOutput("rel_grant1",  wh_grant,  5'b01000);
        applyStimulus(1'b0, '0, 5'b00000, 5'b11111);
        checkOutput("idle_val", wh_val, 5'b00000);

        // Wormhole lock: n holds s for three flits while w waits.
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, S), 5'b00001, 5'b11111);
        checkOutput("wl_sel0",   wh_sel[S], 5'b01000);
        checkOutput("wl_grant0", wh_grant,  5'b01000);
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, S), 5'b00001, 5'b11111);
        checkOutput("wl_sel1",   wh_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, S), 5'b01001, 5'b11111);
        checkOutput("wl_sel2",   wh_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(NONE, NONE, NONE, NONE, S), 5'b00001, 5'b11111);
        checkOutput("wl_sel3",   wh_sel[S], 5'b00001);
        checkOutput("wl_grant3", wh_grant,  5'b00001);

        // Backpressure on s mid-packet; c would win if the lock were dropped.
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, NONE), 5'b00000, 5'b11111);
        checkOutput("bp_sel0", wh_sel[S], 5'b01000);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, mk_req(S, S, NONE, NONE, NONE), 5'b10000, 5'b11101);
            checkOutput("bp_val",   {4'b0000, wh_val[S]}, 5'b00000);
            checkOutput("bp_grant", wh_grant, 5'b00000);
        end
        applyStimulus(1'b0, mk_req(S, S, NONE, NONE, NONE), 5'b11000, 5'b11111);
        checkOutput("bp_resume", wh_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(S, NONE, NONE, NONE, NONE), 5'b10000, 5'b11111);
        checkOutput("bp_after",  wh_sel[S], 5'b10000);
        applyStimulus(1'b0, '0, 5'b00000, 5'b11111);

        // Owner bubble: n goes quiet for a cycle, c must not steal s.
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, NONE), 5'b00000, 5'b11111);
        checkOutput("ob_sel0", wh_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(S, NONE, NONE, NONE, NONE), 5'b10000, 5'b11111);
        checkOutput("ob_val",   {4'b0000, wh_val[S]}, 5'b00000);
        checkOutput("ob_grant", wh_grant, 5'b00000);
        applyStimulus(1'b0, mk_req(S, S, NONE, NONE, NONE), 5'b11000, 5'b11111);
        checkOutput("ob_tail",  wh_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(S, NONE, NONE, NONE, NONE), 5'b10000, 5'b11111);
        checkOutput("ob_next",  wh_sel[S], 5'b10000);
        applyStimulus(1'b0, '0, 5'b00000, 5'b11111);

        // Fairness on output c with single-flit packets from every input.
        for (int i = 0; i < 5; i++) cnt[i] = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, mk_req(C, C, C, C, C), 5'b11111, 5'b11111);
            checkOutput($sformatf("fair_sel%0d", k), wh_sel[C], 5'b10000 >> (k % 5));
            for (int i = 0; i < 5; i++) cnt[i] += int'(wh_grant[i]);
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("fair_cnt%0d", i), cnt[i][4:0], 5'd2);
        end
        applyStimulus(1'b0, '0, 5'b00000, 5'b11111);

        // Reset during a locked packet clears the lock and the pointer.
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, NONE), 5'b00000, 5'b11111);
        checkOutput("rm_sel0", wh_sel[S], 5'b01000);
        applyStimulus(1'b1, mk_req(S, S, NONE, NONE, NONE), 5'b10000, 5'b11111);
        checkOutput("rm_val",   wh_val,   5'b00000);
        checkOutput("rm_grant", wh_grant, 5'b00000);
        applyStimulus(1'b0, mk_req(S, S, NONE, NONE, NONE), 5'b10000, 5'b11111);
        checkOutput("rm_sel1",  wh_sel[S], 5'b10000);
        checkOutput("rm_nw",    nw_sel[S], 5'b10000);
        applyStimulus(1'b0, '0, 5'b00000, 5'b11111);

        // Without wormhole locking, two two-flit senders interleave on s.
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, S), 5'b00000, 5'b11111);
        checkOutput("nw_sel0", nw_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, S), 5'b01000, 5'b11111);
        checkOutput("nw_sel1", nw_sel[S], 5'b00001);
        applyStimulus(1'b0, mk_req(NONE, S, NONE, NONE, S), 5'b01001, 5'b11111);
        checkOutput("nw_sel2", nw_sel[S], 5'b01000);
        applyStimulus(1'b0, mk_req(NONE, NONE, NONE, NONE, S), 5'b00001, 5'b11111);
        checkOutput("nw_sel3",   nw_sel[S], 5'b00001);
        checkOutput("nw_grant3", nw_grant,  5'b00001);
        applyStimulus(1'b0, '0, 5'b00000, 5'b11111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enoc_switch_allocator.md
# enoc_switch_allocator

Output-port allocator for one ENoC router, directly downstream of the per-input route calculators. Takes the one-hot [c,n,e,s,w] output request of each of the five input buffers and arbitrates each output port with an independent round-robin arbiter. In wormhole mode it holds an output for one input until that input's tail flit has transferred. It drives the crossbar select and the input-FIFO pop strobes.

## Interface
- `WORMHOLE`, default 1. 1: an output stays locked to its owner from head to tail. 0: every flit is arbitrated independently.
- `clk`  in  1  router clock.
- `reset`  in  1  synchronous, active-high reset.
- `i_output_req`  in  [0:4][0:4]  per input [c,n,e,s,w]: one-hot output request from that input's route calculator; all zero means no flit.
- `i_tail`  in  [0:4]  per input: the current flit is a tail; a single-flit packet asserts this on its head.
- `i_en`  in  [0:4]  per output: downstream can accept a flit this cycle.
- `o_input_grant`  out  [0:4]  per input: its flit transfers this cycle (FIFO pop).
- `o_output_sel`  out  [0:4][0:4]  per output: one-hot input select for the crossbar.
- `o_output_val`  out  [0:4]  per output: a valid flit leaves this cycle.

## Operation
- Each output `o` has its own state:
  - `ptr[o]`, 0..4: highest-priority input.
  - `lock[o]`, 1 bit.
  - `owner[o]`, 0..4.
- **Candidates for output o**
  - Input `i` is a candidate when `i_output_req[i][o]` is set.
  - If `lock[o]` is set, only `owner[o]` is a candidate.
- **Winner selection**
  - The winner is the first candidate found searching `ptr[o]`, `ptr[o]+1`, … modulo 5.
- **Transfer**
  - A transfer on `o` happens when a winner exists and `i_en[o]` is 1.
  - On a transfer: `o_output_val[o]`=1, `o_output_sel[o]` = onehot(winner), and `o_input_grant[winner]`=1.
  - Otherwise `o_output_val[o]`=0 and `o_output_sel[o]`=0.
- **State update, WORMHOLE=1**
  - Transfer of a non-tail flit: `lock[o]`←1, `owner[o]`←winner.
  - Transfer of a tail flit: `lock[o]`←0, `ptr[o]`←(winner+1) mod 5.
- **State update, WORMHOLE=0**
  - `lock` is never set.
  - `ptr[o]`←(winner+1) mod 5 on every transfer.
- **No transfer:** state is unchanged.
  - This covers `i_en` low, no candidate, and a locked owner with an empty FIFO. A locked owner's bubble leaves the output idle and the lock held.
- **Conflicts:** each input requests at most one output, so the five arbiters never grant the same input twice. No cross-output logic is needed.
- **Illegal request:** `i_output_req[i]` with more than one bit set is illegal. It is flagged by assertion, and the response is unspecified.
- **U-turns:** a request to the same direction as the arrival port is served normally. Filtering belongs to the route calculator.

## Timing
- Grants are combinational from `i_output_req`, `i_tail`, `i_en` and registered state: zero-cycle allocation latency.
- `ptr`, `lock` and `owner` update on the `clk` rising edge following a transfer.
- A new packet can win an output in the cycle immediately after the previous owner's tail transfer.
- Throughput: one flit per output per cycle.
- Reset behaviour:
  - While `reset` is 1, all outputs are forced to 0.
  - At the clock edge: `ptr`←0, `lock`←0, `owner`←0.
  - The first cycle after reset deasserts gives input c (index 0) priority on every output.
- Reset mid-packet drops all locks. Upstream FIFOs are reset in the same cycle.
- Tail and head of consecutive packets from the same input may be back-to-back. After the tail releases the lock, that input is lowest priority at the next arbitration.

## Structure
- Shared package `enoc_pkg` holds:
  - Port index constants `PORT_C`=0, `PORT_N`=1, `PORT_E`=2, `PORT_S`=3, `PORT_W`=4.
  - `typedef logic [0:4] port_onehot_t`.
  - `typedef logic [2:0] port_idx_t`.
  - A mod-5 increment function.
- Sub-module `enoc_rr_arbiter` (5-requester round robin with lock/owner state and the `WORMHOLE` parameter) is instantiated once per output.
- The top level only transposes `i_output_req` into per-output request vectors and ORs the per-output grants into `o_input_grant`.

## Test plan
- Reset release:
  - Stimulus: inputs c and n both request e, `i_tail`=11000, `i_en`=all 1.
  - Required response:
    - Cycle 0: `o_output_sel[e]`=10000, `o_input_grant`=10000.
    - Cycle 1: `o_output_sel[e]`=01000.
- Wormhole lock:
  - Stimulus: n sends a 3-flit packet to s while w also requests s.
  - Required response: s selects n for 3 consecutive cycles, then w in cycle 3.
- Backpressure:
  - Stimulus: `i_en[s]`=0 for 2 cycles mid-packet.
  - Required response: `o_output_val[s]`=0 and no grants for those 2 cycles; the lock is held and n resumes afterwards.
- Owner bubble:
  - Stimulus: the locked owner drops its request for 1 cycle while another input requests the same output.
  - Required response: the output stays idle that cycle; the other input is not granted.
- Fairness:
  - Stimulus: all 5 inputs continuously request c with single-flit packets.
  - Required response: grants rotate c,n,e,s,w,c…; each input is granted exactly 2 times in 10 cycles.
- Reset mid-packet and WORMHOLE=0:
  - Reset asserted during a locked packet: outputs are 0 during reset, and the next cycle arbitrates from `ptr`=0.
  - With WORMHOLE=0, two multi-flit senders to one output interleave flit by flit.
